// File: rtl/mips_pkg.sv
// Shared multiply/divide encodings and FSM state.
package mips_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PREP  = 2'd1,
        ST_CALC  = 2'd2,
        ST_FIXUP = 2'd3
    } md_state_t;

endpackage

// File: rtl/muldiv_core.sv
// Unsigned shift-add multiply / restoring divide datapath, one step per i_step.
// WIDTH steps after i_load; {o_hi,o_lo} is product, or remainder/quotient.
module muldiv_core
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_ITER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_last
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_shf;
    logic [WIDTH-1:0] r_m;
    logic             r_div;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_trial;

    assign w_sum   = {1'b0, r_acc} + {1'b0, r_m};
    // Partial remainder stays below the divisor, so the sign bit of this
    // WIDTH+1-bit difference is a valid "does not fit" flag.
    assign w_trial = {r_acc, r_shf[WIDTH-1]} - {1'b0, r_m};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_shf <= '0;
            r_m   <= '0;
            r_div <= 1'b0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_acc <= '0;
            r_shf <= i_div ? i_a : i_b;
            r_m   <= i_div ? i_b : i_a;
            r_div <= i_div;
            r_cnt <= '0;
        end else if (i_step) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_div) begin
                if (!w_trial[WIDTH]) begin
                    r_acc <= w_trial[WIDTH-1:0];
                    r_shf <= {r_shf[WIDTH-2:0], 1'b1};
                end else begin
                    r_acc <= {r_acc[WIDTH-2:0], r_shf[WIDTH-1]};
                    r_shf <= {r_shf[WIDTH-2:0], 1'b0};
                end
            end else if (r_shf[0]) begin
                {r_acc, r_shf} <= {w_sum, r_shf[WIDTH-1:1]};
            end else begin
                {r_acc, r_shf} <= {1'b0, r_acc, r_shf[WIDTH-1:1]};
            end
        end
    end

    assign o_hi   = r_acc;
    assign o_lo   = r_shf;
    assign o_last = (r_cnt == LAST_CNT);

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO owner with iterative mult/div: WIDTH+2 busy cycles, stall while busy.
// HILO_BYPASS_EN forwards same-cycle mthi/mtlo data onto the read port.
module hilo_muldiv
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_ITER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startE,
    input  logic [1:0]       opE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             mthiW,
    input  logic             mtloW,
    input  logic [WIDTH-1:0] wdataW,
    input  logic             rdhiW,
    input  logic             rdenW,
    output logic [WIDTH-1:0] hi_loW,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    md_state_t r_state, w_next;

    logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo;
    logic [1:0]       r_op;

    logic             w_a_neg, w_b_neg, w_neg_q, w_idle;
    logic [WIDTH-1:0] w_a_mag, w_b_mag, w_core_hi, w_core_lo;
    logic [WIDTH-1:0] w_res_hi, w_res_lo;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;
    logic             w_core_last;

    assign w_idle  = (r_state == ST_IDLE);
    assign w_a_neg = !r_op[0] && r_a[WIDTH-1];
    assign w_b_neg = !r_op[0] && r_b[WIDTH-1];
    assign w_neg_q = w_a_neg ^ w_b_neg;
    assign w_a_mag = w_a_neg ? -r_a : r_a;
    assign w_b_mag = w_b_neg ? -r_b : r_b;

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst    (rst),
        .i_load (r_state == ST_PREP),
        .i_step (r_state == ST_CALC),
        .i_div  (r_op[1]),
        .i_a    (w_a_mag),
        .i_b    (w_b_mag),
        .o_hi   (w_core_hi),
        .o_lo   (w_core_lo),
        .o_last (w_core_last)
    );

    assign w_prod     = {w_core_hi, w_core_lo};
    assign w_prod_fix = w_neg_q ? -w_prod : w_prod;

    always_comb begin
        w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod_fix[WIDTH-1:0];
        if (r_op[1]) begin
            if (r_b == '0) begin
                w_res_hi = r_a;
                w_res_lo = '1;
            end else begin
                w_res_hi = w_a_neg ? -w_core_hi : w_core_hi;
                w_res_lo = w_neg_q ? -w_core_lo : w_core_lo;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (startE) w_next = ST_PREP;
            ST_PREP:  w_next = ST_CALC;
            ST_CALC:  if (w_core_last) w_next = ST_FIXUP;
            ST_FIXUP: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= MD_MULT;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_next;
            if (w_idle && startE) begin
                r_a  <= srcaE;
                r_b  <= srcbE;
                r_op <= opE;
            end
            if (r_state == ST_FIXUP) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else if (w_idle) begin
                if (mthiW) r_hi <= wdataW;
                if (mtloW) r_lo <= wdataW;
            end
        end
    end

`ifdef HILO_BYPASS_EN
    always_comb begin
        if (rdhiW) hi_loW = (w_idle && mthiW) ? wdataW : r_hi;
        else       hi_loW = (w_idle && mtloW) ? wdataW : r_lo;
    end
`else
    assign hi_loW = rdhiW ? r_hi : r_lo;
`endif

    assign busy  = !w_idle;
    assign done  = (r_state == ST_FIXUP);
    assign stall = busy && (startE || rdenW || mthiW || mtloW);

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed vector bench for hilo_muldiv: result table plus reset/stall/bypass sequences.
module tb_hilo_muldiv;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst, startE, mthiW, mtloW, rdhiW, rdenW;
    logic [1:0]  opE;
    logic [31:0] srcaE, srcbE, wdataW, hi_loW;
    logic        busy, done, stall;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hilo_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .startE(startE), .opE(opE),
        .srcaE(srcaE), .srcbE(srcbE), .mthiW(mthiW), .mtloW(mtloW),
        .wdataW(wdataW), .rdhiW(rdhiW), .rdenW(rdenW),
        .hi_loW(hi_loW), .busy(busy), .done(done), .stall(stall)
    );

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reads HI then LO through the port; called at a negedge in IDLE.
    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        rdhiW = 1'b1; #1; hi = hi_loW;
        rdhiW = 1'b0; #1; lo = hi_loW;
    endtask

    // Accepts one op, scrambles operands afterwards, and counts busy/done cycles.
    // Returns at the negedge of the first IDLE cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cnt, output int done_cnt, output int done_last);
        @(negedge clk);
        startE = 1'b1; opE = op; srcaE = a; srcbE = b;
        @(negedge clk);
        startE = 1'b0; srcaE = $urandom; srcbE = $urandom; opE = 2'($urandom);
        busy_cnt = 0; done_cnt = 0; done_last = 0;
        for (int c = 0; c < 100; c++) begin
            if (!busy) break;
            busy_cnt++;
            done_last = done ? 1 : 0;
            if (done) done_cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int bc, dc, dl, bad;
        logic [31:0] h, l;

        vecs[0]  = '{"multu_max",  MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{"mult_m2x3",  MD_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[2]  = '{"div_m7_2",   MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{"divu_by0",   MD_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
        vecs[4]  = '{"div_ovf",    MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{"divu_100_7", MD_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        vecs[6]  = '{"mult_7xm5",  MD_MULT,  32'h00000007, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD};
        vecs[7]  = '{"div_7_m2",   MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8]  = '{"div_m5_by0", MD_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[9]  = '{"mult_minsq", MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[10] = '{"multu_sh4",  MD_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};

        rst = 1'b1; startE = 1'b0; opE = MD_MULT; srcaE = '0; srcbE = '0;
        mthiW = 1'b0; mtloW = 1'b0; wdataW = '0; rdhiW = 1'b0; rdenW = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        read_hilo(h, l);
        chk("rst_hi", h, 32'd0);
        chk("rst_lo", l, 32'd0);

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, bc, dc, dl);
            read_hilo(h, l);
            chk({vecs[i].name, "_hi"}, h, vecs[i].hi);
            chk({vecs[i].name, "_lo"}, l, vecs[i].lo);
            if (i < 3) begin
                chk({vecs[i].name, "_busycyc"}, 32'(bc), 32'd34);
                chk({vecs[i].name, "_donecnt"}, 32'(dc), 32'd1);
                chk({vecs[i].name, "_donelast"}, 32'(dl), 32'd1);
            end
        end

        // Reset during CALC iteration 10 aborts and clears HI/LO (last result HI=1).
        @(negedge clk);
        startE = 1'b1; opE = MD_MULTU; srcaE = 32'hFFFFFFFF; srcbE = 32'h2;
        @(negedge clk);
        startE = 1'b0;
        repeat (11) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        read_hilo(h, l);
        chk("midrst_hi", h, 32'd0);
        chk("midrst_lo", l, 32'd0);
        run_op(MD_MULTU, 32'd3, 32'd4, bc, dc, dl);
        read_hilo(h, l);
        chk("after_rst_hi", h, 32'd0);
        chk("after_rst_lo", l, 32'd12);

        // Busy with rdenW held: stall every cycle; start/mthi/mtlo during busy ignored.
        @(negedge clk);
        chk("idle_stall", 32'(stall), 32'd0);
        startE = 1'b1; opE = MD_MULT; srcaE = 32'd6; srcbE = 32'd7;
        @(negedge clk);
        startE = 1'b0; rdenW = 1'b1;
        bc = 0; bad = 0;
        for (int c = 0; c < 100; c++) begin
            if (!busy) break;
            if (!stall) bad++;
            bc++;
            if (bc == 5) begin
                startE = 1'b1; opE = MD_DIVU; srcaE = 32'd1; srcbE = 32'd1;
                mthiW = 1'b1; mtloW = 1'b1; wdataW = 32'hDEADBEEF;
            end else if (bc == 7) begin
                startE = 1'b0; mthiW = 1'b0; mtloW = 1'b0;
            end
            @(negedge clk);
        end
        rdenW = 1'b0;
        chk("stall_bad_cycles", 32'(bad), 32'd0);
        chk("stall_busycyc", 32'(bc), 32'd34);
        read_hilo(h, l);
        chk("ignored_hi", h, 32'd0);
        chk("ignored_lo", l, 32'd42);
        @(negedge clk);
        chk("no_late_start", 32'(busy), 32'd0);

        // Read port bypass of same-cycle mthi, and mtlo.
        mthiW = 1'b1; wdataW = 32'hAAAA5555;
        @(negedge clk);
        mthiW = 1'b0;
        rdhiW = 1'b1; #1;
        chk("mthi_setup", hi_loW, 32'hAAAA5555);
        mthiW = 1'b1; rdenW = 1'b1; wdataW = 32'h12345678; #1;
`ifdef HILO_BYPASS_EN
        chk("bypass_hi", hi_loW, 32'h12345678);
`else
        chk("bypass_hi", hi_loW, 32'hAAAA5555);
`endif
        @(negedge clk);
        mthiW = 1'b0; rdenW = 1'b0; #1;
        chk("mthi_next", hi_loW, 32'h12345678);
        rdhiW = 1'b0; mtloW = 1'b1; wdataW = 32'h0BADF00D; #1;
`ifdef HILO_BYPASS_EN
        chk("bypass_lo", hi_loW, 32'h0BADF00D);
`else
        chk("bypass_lo", hi_loW, 32'd42);
`endif
        @(negedge clk);
        mtloW = 1'b0; #1;
        chk("mtlo_next", hi_loW, 32'h0BADF00D);

        // mthi with start in the same IDLE cycle: result overwrites it.
        @(negedge clk);
        mthiW = 1'b1; wdataW = 32'h55555555;
        run_op(MD_DIVU, 32'd9, 32'd4, bc, dc, dl);
        read_hilo(h, l);
        chk("mthi_start_hi", h, 32'd1);
        chk("mthi_start_lo", l, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Iterative multiply/divide unit that produces the HI/LO register pair read by the writeback stage for mfhi/mflo. It accepts mult/multu/div/divu from the execute stage, runs a fixed-latency shift-add / restoring-divide sequence, and stalls the pipeline while busy. It owns the architectural HI and LO registers, their mthi/mtlo write port, and the read port that drives writeback's hi_lo data.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width; must be even and at least 8.

Ports:
- clk  in  1  pipeline clock; every register updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- startE  in  1  request to begin the operation selected by opE.
- opE  in  2  00 mult, 01 multu, 10 div, 11 divu.
- srcaE  in  WIDTH  multiplicand or dividend.
- srcbE  in  WIDTH  multiplier or divisor.
- mthiW  in  1  write wdataW to HI.
- mtloW  in  1  write wdataW to LO.
- wdataW  in  WIDTH  mthi/mtlo data.
- rdhiW  in  1  read-port select: 1 selects HI, 0 selects LO.
- rdenW  in  1  an mfhi or mflo instruction is using the read port.
- hi_loW  out  WIDTH  selected HI or LO value (combinational).
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse in the cycle whose ending edge writes HI/LO.
- stall  out  1  equals busy & (startE | rdenW | mthiW | mtloW).

## Operation
- States:
  - IDLE: start is accepted only in this state.
  - PREP: latch magnitudes and result signs.
  - CALC: WIDTH iterations counted by a log2(WIDTH)+1-bit counter.
  - FIXUP: apply signs, assert done, write HI/LO.
- Transitions:
  - IDLE→PREP on startE.
  - PREP→CALC.
  - CALC→FIXUP when the counter reaches WIDTH-1.
  - FIXUP→IDLE.
- Multiply: 2·WIDTH-bit product. HI = upper half, LO = lower half. Signed ops negate the product when the operand signs differ.
- Divide: LO = quotient, HI = remainder, using truncating division.
  - The remainder takes the dividend's sign.
  - 0x80000000 / -1 gives LO=0x80000000, HI=0 (two's-complement wrap).
- Divide by zero (either signedness): skip sign fixup; LO=all ones, HI=srcaE.
- Operands are sampled only in the accept cycle. Later changes to srcaE or srcbE have no effect.
- mthiW/mtloW:
  - Applied only in IDLE; ignored while busy, and stall forces the pipeline to hold them.
  - In IDLE, mthiW/mtloW together with startE: the write is applied and the later result overwrites it.
- startE while busy: ignored; stall is high.
- rst: state=IDLE, HI=0, LO=0, busy=0, done=0, counter=0. It aborts any operation in flight and discards its result.

## Timing
- Accept edge E0 (startE in IDLE). busy is high from the cycle after E0 through the FIXUP cycle: WIDTH+2 cycles, 34 for WIDTH=32.
- done is high in the FIXUP cycle. HI/LO hold the new values from the following cycle, when busy=0.
- A back-to-back start is accepted in the first IDLE cycle.
- hi_loW is combinational from HI/LO. While busy it shows the old value, but stall is high whenever rdenW is set.
- Reset is sampled only on clk edges. Outputs take reset values in the cycle after rst is seen high.

## Configuration
- HILO_BYPASS_EN defined: in IDLE, when mthiW (mtloW) is high and rdhiW selects HI (LO), hi_loW returns wdataW in the same cycle.
- HILO_BYPASS_EN undefined: hi_loW returns the pre-write register value. Hazard control must separate the mthi/mtlo from the dependent read by one cycle.

## Structure
- Shared package mips_pkg holds:
  - op encodings MD_MULT/MD_MULTU/MD_DIV/MD_DIVU;
  - the state enum;
  - MD_ITER=32.
- Sub-module muldiv_core:
  - holds the iteration datapath: accumulator/remainder, shift register, counter;
  - computes one step per cycle under a step enable.
- Top level owns the FSM, sign handling, HI/LO, the read mux and the bypass.

## Test plan
- multu 0xFFFFFFFF×0xFFFFFFFF → busy 34 cycles, done pulse, then HI=0xFFFFFFFE, LO=0x00000001.
- mult −2×3 → HI=0xFFFFFFFF, LO=0xFFFFFFFA; div −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu 100/0 → LO=0xFFFFFFFF, HI=0x00000064; div 0x80000000/−1 → LO=0x80000000, HI=0.
- rst high during CALC iteration 10 → next cycle busy=0, HI=LO=0; new multu 3×4 then gives LO=12, HI=0.
- rdenW=1 during busy → stall=1 every cycle until busy drops; startE during busy is ignored and stall=1.
- mthiW with wdataW=0x12345678 and rdhiW=1 rdenW=1 in the same cycle → hi_loW=0x12345678 with HILO_BYPASS_EN, old HI without it; next cycle it reads 0x12345678 in both builds.
